// File: rtl/alu_logic_pkg.sv
// Shared encodings for the ALU bitwise logic unit and the ALU control decoder.
package alu_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bitwise logic function plus result flags, sized by WIDTH.
module alu_logic_core
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] result_s;

  // Select the bitwise function; B is unused for NOT and PASS.
  always_comb begin
    result_s = a;
    case (op)
      OP_NOT:  result_s = ~a;
      OP_AND:  result_s = a & b;
      OP_OR:   result_s = a | b;
      OP_XOR:  result_s = a ^ b;
      OP_NAND: result_s = ~(a & b);
      OP_NOR:  result_s = ~(a | b);
      OP_XNOR: result_s = ~(a ^ b);
      OP_PASS: result_s = a;
      default: result_s = a;
    endcase
  end

  assign result = result_s;
  assign zero   = (result_s == {WIDTH{1'b0}});
  assign ones   = (result_s == {WIDTH{1'b1}});
  assign parity = parity_of(result_s);

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with tag passthrough,
// result flags and a delivered-result counter.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_r;
  logic [OP_W-1:0]  s1_op_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_result_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             s2_zero_r;
  logic             s2_ones_r;
  logic             s2_parity_r;

  logic [CNT_W-1:0] count_r;

  logic             s2_free_s;
  logic             s1_move_s;
  logic             in_hs_s;
  logic             out_hs_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_zero_s;
  logic             core_ones_s;
  logic             core_parity_s;

  assign s2_free_s = !s2_valid_r || out_ready;
  assign s1_move_s = s1_valid_r && s2_free_s;
  assign in_ready  = !s1_valid_r || s1_move_s;
  assign in_hs_s   = in_valid && in_ready;
  assign out_hs_s  = s2_valid_r && out_ready;

  alu_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (s1_op_r),
    .a      (s1_a_r),
    .b      (s1_b_r),
    .result (core_result_s),
    .zero   (core_zero_s),
    .ones   (core_ones_s),
    .parity (core_parity_s)
  );

  // Stage 1: capture the operands on an input handshake, release when passed on.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= {OP_W{1'b0}};
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_tag_r   <= {TAG_W{1'b0}};
    end else if (in_hs_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= in_op;
      s1_a_r     <= in_a;
      s1_b_r     <= in_b;
      s1_tag_r   <= in_tag;
    end else if (s1_move_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: the data registers are zeroed whenever empty, so the outputs read 0 while invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= {WIDTH{1'b0}};
      s2_tag_r    <= {TAG_W{1'b0}};
      s2_zero_r   <= 1'b0;
      s2_ones_r   <= 1'b0;
      s2_parity_r <= 1'b0;
    end else if (s1_move_s) begin
      s2_valid_r  <= 1'b1;
      s2_result_r <= core_result_s;
      s2_tag_r    <= s1_tag_r;
      s2_zero_r   <= core_zero_s;
      s2_ones_r   <= core_ones_s;
      s2_parity_r <= core_parity_s;
    end else if (s2_free_s) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= {WIDTH{1'b0}};
      s2_tag_r    <= {TAG_W{1'b0}};
      s2_zero_r   <= 1'b0;
      s2_ones_r   <= 1'b0;
      s2_parity_r <= 1'b0;
    end
  end

  // Count delivered results, wrapping modulo 2^CNT_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid  = s2_valid_r;
  assign out_result = s2_result_r;
  assign out_tag    = s2_tag_r;
  assign out_zero   = s2_zero_r;
  assign out_ones   = s2_ones_r;
  assign out_parity = s2_parity_r;
  assign op_count   = count_r;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench for alu_logic_pipe: per-bit truth-table reference model
// and a queue scoreboard of accepted-but-undelivered operations.
module tb_alu_logic_pipe;

  localparam int W  = 33;
  localparam int TW = 5;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_zero, out_ones, out_parity;
  logic [CW-1:0] op_count;

  always #5 clock = ~clock;

  alu_logic_pipe #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_ones(out_ones),
    .out_parity(out_parity), .op_count(op_count)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  // snapshot of one cycle, taken 1 time unit after the falling edge
  bit            s_acc, s_del, s_ready, s_valid, s_have;
  exp_t          s_exp;
  logic [W-1:0]  s_result;
  logic [TW-1:0] s_tag;
  logic          s_zero, s_ones, s_par;
  logic [CW-1:0] s_cnt;
  int            s_exp_cnt, s_inflight;

  // per-bit output for each input pair, indexed by {a_bit, b_bit}
  function automatic logic [3:0] truth(input int op);
    case (op)
      0: return 4'b0011;
      1: return 4'b1000;
      2: return 4'b1110;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b0001;
      6: return 4'b1001;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0]   t;
    logic [W-1:0] r;
    t = truth(op);
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  function automatic int popc(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic tick(input bit v, input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int tag, input bit ordy);
    @(negedge clock);
    in_valid = v; in_op = op[2:0]; in_a = a; in_b = b; in_tag = tag[TW-1:0]; out_ready = ordy;
    #1;
    s_ready = in_ready; s_valid = out_valid; s_result = out_result; s_tag = out_tag;
    s_zero = out_zero; s_ones = out_ones; s_par = out_parity; s_cnt = op_count;
    s_inflight = sb.size(); s_exp_cnt = exp_cnt;
    s_acc = v && in_ready;
    s_del = out_valid && ordy;
    s_have = 1'b0;
    if (s_del && sb.size() > 0) begin
      s_exp = sb.pop_front();
      s_have = 1'b1;
    end
    if (s_del) exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (s_acc) sb.push_back('{ref_op(op, a, b), tag[TW-1:0]});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0 || out_zero !== 1'b0 ||
        out_ones !== 1'b0 || out_parity !== 1'b0 || op_count !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b res=%h tag=%0d z%b o%b p%b cnt=%0d, want all 0",
               out_valid, out_result, out_tag, out_zero, out_ones, out_parity, op_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    sb.delete(); exp_cnt = 0;
    tick(0, 0, '0, '0, 0, 1);
    checks++;
    if (s_ready !== 1'b1 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", s_ready, s_valid);
    end
  endtask

  task automatic test_single();
    tick(1, 0, '0, '0, 3, 1);
    tick(0, 0, '0, '0, 0, 1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency: out_valid=%b one cycle after accept, want 0", s_valid);
    end
    tick(0, 0, '0, '0, 0, 1);
    checks++;
    if (s_valid !== 1'b1 || s_result !== 33'h1_FFFF_FFFF || s_ones !== 1'b1 || s_zero !== 1'b0 ||
        s_par !== 1'b1 || s_tag !== 5'd3) begin
      errors++;
      $display("FAIL single_not: valid=%b res=%h o%b z%b p%b tag=%0d, want 1 1ffffffff 1 0 1 3",
               s_valid, s_result, s_ones, s_zero, s_par, s_tag);
    end
    tick(0, 0, '0, '0, 0, 1);
    checks++;
    if (s_cnt !== 4'd1 || s_valid !== 1'b0) begin
      errors++; $display("FAIL single_count: op_count=%0d valid=%b, want 1 0", s_cnt, s_valid);
    end
  endtask

  task automatic test_modes();
    logic [W-1:0] a, b;
    logic [W-1:0] tab [8];
    int           seen = 0;
    a = 33'h1_0000_00F0; b = 33'h0_0000_0FF0;
    tab[0] = 33'h0_FFFF_FF0F; tab[1] = 33'h0_0000_00F0; tab[2] = 33'h1_0000_0FF0;
    tab[3] = 33'h1_0000_0F00; tab[4] = 33'h1_FFFF_FF0F; tab[5] = 33'h0_FFFF_F00F;
    tab[6] = 33'h0_FFFF_F0FF; tab[7] = a;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) tick(1, i, a, b, i, 1);
      else       tick(0, 0, '0, '0, 0, 1);
      if (s_del) begin
        seen++;
        checks++;
        if (!s_have || s_tag !== s_exp.tag || s_result !== tab[s_tag[2:0]] || s_result !== s_exp.res ||
            s_zero !== 1'(popc(s_exp.res) == 0) || s_ones !== 1'(popc(s_exp.res) == W) ||
            s_par !== 1'(popc(s_exp.res) % 2)) begin
          errors++;
          $display("FAIL mode_%0d: res=%h z%b o%b p%b, want %h", s_tag, s_result, s_zero, s_ones, s_par, tab[s_tag[2:0]]);
        end
      end
    end
    checks++;
    if (seen != 8) begin
      errors++; $display("FAIL modes_count: delivered %0d, want 8", seen);
    end
  endtask

  task automatic test_back_to_back();
    int c0 = exp_cnt;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) tick(1, int'($urandom_range(7)), rnd_w(), rnd_w(), i, 1);
      else        tick(0, 0, '0, '0, 0, 1);
      checks++;
      if ((i < 10 && s_ready !== 1'b1) || s_del !== (i >= 2)) begin
        errors++; $display("FAIL b2b_flow[%0d]: in_ready=%b delivered=%b, want 1 %b", i, s_ready, s_del, i >= 2);
      end
      if (s_del) begin
        checks++;
        if (!s_have || s_tag !== TW'(i - 2) || s_result !== s_exp.res ||
            s_zero !== 1'(popc(s_exp.res) == 0) || s_ones !== 1'(popc(s_exp.res) == W) ||
            s_par !== 1'(popc(s_exp.res) % 2)) begin
          errors++;
          $display("FAIL b2b_data[%0d]: res=%h tag=%0d, want %h tag %0d", i, s_result, s_tag, s_exp.res, i - 2);
        end
      end
    end
    tick(0, 0, '0, '0, 0, 1);
    checks++;
    if (s_cnt !== CW'((c0 + 10) % (1 << CW))) begin
      errors++; $display("FAIL b2b_count: op_count=%0d, want %0d", s_cnt, (c0 + 10) % (1 << CW));
    end
  endtask

  task automatic test_backpressure();
    int           p_op = 1, p_tag = 10, n_acc = 0, k = 0;
    logic [W-1:0] p_a, p_b, h_res;
    logic [TW-1:0] h_tag;
    logic [2:0]   h_fl;
    p_a = rnd_w(); p_b = rnd_w();
    for (int i = 0; i < 5; i++) begin
      tick(1, p_op, p_a, p_b, p_tag, 0);
      checks++;
      if (s_ready !== (i < 2)) begin
        errors++; $display("FAIL bp_ready[%0d]: in_ready=%b, want %b", i, s_ready, i < 2);
      end
      if (i == 2) begin
        h_res = s_result; h_tag = s_tag; h_fl = {s_zero, s_ones, s_par};
      end else if (i > 2) begin
        checks++;
        if (s_valid !== 1'b1 || s_result !== h_res || s_tag !== h_tag || {s_zero, s_ones, s_par} !== h_fl) begin
          errors++; $display("FAIL bp_stable[%0d]: res=%h tag=%0d, want %h tag %0d held", i, s_result, s_tag, h_res, h_tag);
        end
      end
      if (s_acc) begin
        n_acc++; p_tag++; p_op = int'($urandom_range(7)); p_a = rnd_w(); p_b = rnd_w();
      end
    end
    checks++;
    if (n_acc != 2) begin
      errors++; $display("FAIL bp_captured: %0d ops captured, want 2", n_acc);
    end
    for (int i = 0; i < 20 && (i < 4 || sb.size() > 0 || out_valid); i++) begin
      if (i < 4) tick(1, p_op, p_a, p_b, p_tag, 1);
      else       tick(0, 0, '0, '0, 0, 1);
      if (s_acc) begin
        p_tag++; p_op = int'($urandom_range(7)); p_a = rnd_w(); p_b = rnd_w();
      end
      if (s_del) begin
        checks++;
        if (!s_have || s_tag !== TW'(10 + k) || s_result !== s_exp.res || s_tag !== s_exp.tag) begin
          errors++; $display("FAIL bp_order: res=%h tag=%0d, want %h tag %0d", s_result, s_tag, s_exp.res, 10 + k);
        end
        k++;
      end
    end
    checks++;
    if (sb.size() != 0 || k != p_tag - 10) begin
      errors++; $display("FAIL bp_drain: delivered %0d of %0d, %0d left", k, p_tag - 10, sb.size());
    end
  endtask

  task automatic test_random();
    int           p_op, p_tag = 0;
    logic [W-1:0] p_a, p_b;
    bit           v, r;
    p_op = int'($urandom_range(7)); p_a = rnd_w(); p_b = rnd_w();
    for (int i = 0; i < 340 && (i < 300 || sb.size() > 0 || out_valid); i++) begin
      v = (i < 300) && ($urandom_range(3) != 0);
      r = (i >= 300) || ($urandom_range(2) != 0);
      tick(v, p_op, p_a, p_b, p_tag, r);
      checks++;
      if (s_ready !== (s_inflight < 2 || r) || s_cnt !== CW'(s_exp_cnt)) begin
        errors++; $display("FAIL rand_ctrl[%0d]: in_ready=%b cnt=%0d, want %b %0d", i, s_ready, s_cnt, s_inflight < 2 || r, s_exp_cnt);
      end
      if (s_acc) begin
        p_tag = (p_tag + 1) % (1 << TW); p_op = int'($urandom_range(7)); p_a = rnd_w(); p_b = rnd_w();
      end
      if (s_del) begin
        checks++;
        if (!s_have || s_tag !== s_exp.tag || s_result !== s_exp.res ||
            s_zero !== 1'(popc(s_exp.res) == 0) || s_ones !== 1'(popc(s_exp.res) == W) ||
            s_par !== 1'(popc(s_exp.res) % 2)) begin
          errors++; $display("FAIL rand_data[%0d]: res=%h tag=%0d, want %h tag %0d", i, s_result, s_tag, s_exp.res, s_exp.tag);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rand_drain: %0d results never delivered", sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    tick(1, 3, rnd_w(), rnd_w(), 1, 0);
    tick(1, 5, rnd_w(), rnd_w(), 2, 0);
    tick(0, 0, '0, '0, 0, 0);
    checks++;
    if (s_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full: out_valid=%b in_ready=%b, want 1 0", s_valid, s_ready);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== '0 || out_result !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL mid_async: valid=%b cnt=%0d res=%h, want 0 0 0", out_valid, op_count, out_result);
    end
    sb.delete(); exp_cnt = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, '0, '0, 0, 1);
      checks++;
      if (s_valid !== 1'b0 || s_cnt !== '0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL mid_stale[%0d]: valid=%b cnt=%0d ready=%b, want 0 0 1", i, s_valid, s_cnt, s_ready);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] a;
    int           n = 0;
    a = 33'h1_2345_6789;
    for (int i = 0; i < 30 && (i < 17 || sb.size() > 0 || out_valid); i++) begin
      if (i < 17) tick(1, 3, a, a, i, 1);
      else        tick(0, 0, '0, '0, 0, 1);
      if (s_del) begin
        n++;
        checks++;
        if (s_result !== '0 || s_zero !== 1'b1 || s_parity_bad(s_par) || s_ones !== 1'b0) begin
          errors++; $display("FAIL wrap_xor: res=%h z%b o%b p%b, want 0 1 0 0", s_result, s_zero, s_ones, s_par);
        end
      end
    end
    tick(0, 0, '0, '0, 0, 1);
    checks++;
    if (n != 17 || s_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_count: delivered %0d op_count=%0d, want 17 1", n, s_cnt);
    end
  endtask

  function automatic bit s_parity_bad(input logic p);
    return p !== 1'b0;
  endfunction

  initial begin
    test_reset();
    test_single();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
